// File: rtl/ra_writer_if.sv
// ra_writer_if: VRAM write port between the RA generator (master) and the VRAM arbiter (slave)
interface ra_writer_if #(
  parameter int ADDR_W = 24
);
  logic              ra_vram_wr;
  logic [ADDR_W-1:0] ra_vram_addr;
  logic [31:0]       ra_vram_dout;
  logic              ra_vram_wait;
  modport master (output ra_vram_wr, ra_vram_addr, ra_vram_dout, input ra_vram_wait);
  modport slave (input ra_vram_wr, ra_vram_addr, ra_vram_dout, output ra_vram_wait);
endinterface

// File: rtl/ra_writer.sv
// ra_writer: Region Array generator writing one RA entry per tile to VRAM; RA_DUMMY_HEAD_EN adds a blank head entry
module ra_writer #(
  parameter int ADDR_W = 24,
  parameter int TILE_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ra_gen_trig,
  input  logic [31:0]       FPU_PARAM_CFG,
  input  logic [31:0]       TA_ALLOC_CTRL,
  input  logic [31:0]       REGION_BASE,
  input  logic [ADDR_W-1:0] OL_BASE,
  input  logic [TILE_W-1:0] tiles_x_m1,
  input  logic [TILE_W-1:0] tiles_y_m1,
  input  logic              ra_zclear,
  input  logic              ra_flush,
  ra_writer_if.master       vram,
  output logic              ra_busy,
  output logic              ra_done,
  output logic [ADDR_W-1:0] ol_end
);
  typedef enum logic [2:0] {IDLE, SETUP, PREP, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic v2, zclear, flush, head;
  logic [1:0] fld [5];
  logic [7:0] sz [5];
  logic [ADDR_W-1:0] base [5];
  logic [ADDR_W-1:0] ptr [5];
  logic [TILE_W-1:0] xm1, ym1, x, y;
  logic [ADDR_W-1:0] pool, addr, inc;
  logic [2:0] k, w, t;
  logic [12:0] num_tiles;
  logic accept, entry_end, last_tile;
  logic [31:0] word;
  logic unused_cfg;
  assign unused_cfg = ^{FPU_PARAM_CFG[31:22], FPU_PARAM_CFG[20:0], TA_ALLOC_CTRL[31:18],
                        TA_ALLOC_CTRL[15:14], TA_ALLOC_CTRL[11:10], TA_ALLOC_CTRL[7:6],
                        TA_ALLOC_CTRL[3:2], REGION_BASE[31:23]};
  // Per-type OPB size in bytes: 0 when the field is 0 (and pt in v1), else 16 << field
  for (genvar i = 0; i < 5; i++) begin : g_sz
    assign sz[i] = (fld[i] == 2'd0 || (i == 4 && !v2)) ? 8'd0 : 8'd16 << fld[i];
  end
  assign num_tiles = (13'(xm1) + 13'd1) * (13'(ym1) + 13'd1);
  assign inc       = sz[k] == 8'd0 ? '0 : ADDR_W'(num_tiles) << (3'd4 + 3'(fld[k]));
  assign accept    = vram.ra_vram_wr && !vram.ra_vram_wait;
  assign entry_end = w == (v2 ? 3'd5 : 3'd4);
  assign last_tile = !head && x == xm1 && y == ym1;
  assign t         = w - 3'd1;
  assign vram.ra_vram_addr = addr;
  // Word being offered: control word at w=0, then one pointer per list type
  always_comb begin
    word = 32'h8000_0000;
    if (w == 3'd0)
      word = head ? {1'b0, zclear, 1'b0, flush, 28'd0}
                  : {last_tile, zclear, 1'b0, flush, 14'd0, 6'(y), 6'(x), 2'b00};
    else if (!head && sz[t] != 8'd0)
      word = {8'h00, 24'(ptr[t])};
  end
  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // Next state and handshake outputs
  always_comb begin
    state_nx = state;
    vram.ra_vram_wr = state == WRITE;
    vram.ra_vram_dout = state == WRITE ? word : 32'd0;
    ra_busy = state == SETUP || state == PREP || state == WRITE;
    ra_done = state == DONE;
    case (state)
      IDLE:    state_nx = ra_gen_trig ? SETUP : IDLE;
      SETUP:   state_nx = k == 3'd4 ? PREP : SETUP;
      PREP:    state_nx = WRITE;
      WRITE:   state_nx = (accept && entry_end && last_tile) ? DONE : WRITE;
      default: state_nx = IDLE;
    endcase
  end
  // Configuration snapshot taken when a trigger is accepted
  always_ff @(posedge clock) begin
    if (reset) begin
      v2 <= 1'b0;
      zclear <= 1'b0;
      flush <= 1'b0;
      xm1 <= '0;
      ym1 <= '0;
      for (int i = 0; i < 5; i++) fld[i] <= 2'd0;
    end else if (state == IDLE && ra_gen_trig) begin
      v2 <= FPU_PARAM_CFG[21];
      zclear <= ra_zclear;
      flush <= ra_flush;
      xm1 <= tiles_x_m1;
      ym1 <= tiles_y_m1;
      for (int i = 0; i < 5; i++) fld[i] <= TA_ALLOC_CTRL[4*i +: 2];
    end
  end
  // Pool carving: one list type per SETUP cycle, pool grows by num_tiles*size via shift
  always_ff @(posedge clock) begin
    if (reset) begin
      k <= 3'd0;
      pool <= '0;
      ol_end <= '0;
      for (int i = 0; i < 5; i++) base[i] <= '0;
    end else if (state == IDLE && ra_gen_trig) begin
      k <= 3'd0;
      pool <= OL_BASE;
    end else if (state == SETUP) begin
      base[k] <= pool;
      pool <= pool + inc;
      ol_end <= pool + inc;
      k <= k + 3'd1;
    end
  end
  // Tile walk: address, word index, tile coordinates and per-type cursors
  always_ff @(posedge clock) begin
    if (reset) begin
      addr <= '0;
      w <= 3'd0;
      x <= '0;
      y <= '0;
      for (int i = 0; i < 5; i++) ptr[i] <= '0;
    end else if (state == IDLE && ra_gen_trig) begin
      addr <= ADDR_W'(REGION_BASE[22:0]);
    end else if (state == PREP) begin
      w <= 3'd0;
      x <= '0;
      y <= '0;
      for (int i = 0; i < 5; i++) ptr[i] <= base[i];
    end else if (accept) begin
      addr <= addr + ADDR_W'(4);
      w <= entry_end ? 3'd0 : w + 3'd1;
      if (entry_end && !head) begin
        x <= x == xm1 ? '0 : x + TILE_W'(1);
        y <= x == xm1 ? y + TILE_W'(1) : y;
        for (int i = 0; i < 5; i++) ptr[i] <= ptr[i] + ADDR_W'(sz[i]);
      end
    end
  end
`ifdef RA_DUMMY_HEAD_EN
  // Head entry is pending from PREP until its last word is accepted
  always_ff @(posedge clock) begin
    if (reset) head <= 1'b0;
    else if (state == PREP) head <= 1'b1;
    else if (accept && entry_end) head <= 1'b0;
  end
`else
  assign head = 1'b0;
`endif
endmodule

// File: tb/tb_ra_writer.sv
// tb_ra_writer: directed table-driven bench for the Region Array generator
module tb_ra_writer;
`ifdef RA_DUMMY_HEAD_EN
  localparam int HEAD = 1;
`else
  localparam int HEAD = 0;
`endif
  typedef struct {
    logic [31:0] fpu, alloc, region;
    logic [23:0] olb;
    logic [5:0]  xm1, ym1;
    logic        zc, fl;
    int          nw, ntiles;
    logic [23:0] olend;
  } cfg_t;
  typedef struct {
    int          c, idx;
    logic [23:0] addr;
    logic [31:0] data;
  } exp_t;
  logic clock = 1'b0, reset = 1'b1, trig = 1'b0;
  logic [31:0] fpu = '0, alloc = '0, region = '0;
  logic [23:0] olb = '0;
  logic [5:0] txm1 = '0, tym1 = '0;
  logic zc = 1'b0, fl = 1'b0;
  logic busy, done;
  logic [23:0] ol_end;
  cfg_t cfgs [4];
  exp_t exps [$];
  logic [23:0] cap_a [128];
  logic [31:0] cap_d [128];
  int ncap, tests = 0, fails = 0;
  ra_writer_if #(.ADDR_W(24)) vram ();
  ra_writer #(.ADDR_W(24), .TILE_W(6)) dut (
    .clock(clock), .reset(reset), .ra_gen_trig(trig), .FPU_PARAM_CFG(fpu),
    .TA_ALLOC_CTRL(alloc), .REGION_BASE(region), .OL_BASE(olb),
    .tiles_x_m1(txm1), .tiles_y_m1(tym1), .ra_zclear(zc), .ra_flush(fl),
    .vram(vram), .ra_busy(busy), .ra_done(done), .ol_end(ol_end)
  );
  always #5 clock = ~clock;
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic run(input int c, input bit rnd, input int abort_at, input bit poke);
    int lat, last_acc, off;
    bit stalled, fin, abort;
    logic [23:0] pa;
    logic [31:0] pd;
    @(negedge clock);
    fpu = cfgs[c].fpu; alloc = cfgs[c].alloc; region = cfgs[c].region; olb = cfgs[c].olb;
    txm1 = cfgs[c].xm1; tym1 = cfgs[c].ym1; zc = cfgs[c].zc; fl = cfgs[c].fl;
    vram.ra_vram_wait = 1'b0;
    trig = 1'b1;
    ncap = 0; lat = -1; last_acc = -10; stalled = 0; fin = 0; abort = 0; pa = '0; pd = '0;
    for (int cyc = 1; cyc < 3000 && !fin; cyc++) begin
      @(negedge clock);
      trig = 1'b0;
      if (abort) begin
        chk("abort_wr", 32'(vram.ra_vram_wr), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        return;
      end
      if (cyc == 1) begin
        chk("busy_on_start", 32'(busy), 32'd1);
        fpu = ~fpu; alloc = 32'h0000_2222; region = 32'h0012_3450; olb = 24'hABCDE0;
        txm1 = ~txm1; tym1 = 6'd5; zc = ~zc; fl = ~fl;
      end
      if (stalled) begin
        chk("stall_wr", 32'(vram.ra_vram_wr), 32'd1);
        chk("stall_addr", 32'(vram.ra_vram_addr), 32'(pa));
        chk("stall_data", vram.ra_vram_dout, pd);
      end
      if (poke && cyc == 20) trig = 1'b1;
      if (done) begin
        chk("done_after_last_accept", 32'(cyc - last_acc), 32'd1);
        chk("busy_with_done", 32'(busy), 32'd0);
        chk($sformatf("c%0d_ol_end", c), 32'(ol_end), 32'(cfgs[c].olend));
        if (poke) trig = 1'b1;
        fin = 1;
      end else begin
        vram.ra_vram_wait = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        if (vram.ra_vram_wr && lat < 0) lat = cyc;
        stalled = vram.ra_vram_wr && vram.ra_vram_wait;
        pa = vram.ra_vram_addr;
        pd = vram.ra_vram_dout;
        if (vram.ra_vram_wr && !vram.ra_vram_wait) begin
          if (ncap < 128) begin
            cap_a[ncap] = vram.ra_vram_addr;
            cap_d[ncap] = vram.ra_vram_dout;
          end
          ncap++;
          last_acc = cyc;
          if (ncap == abort_at) begin
            reset = 1'b1;
            abort = 1;
          end
        end
      end
    end
    if (!fin) begin
      chk("run_timeout", 32'd0, 32'd1);
      return;
    end
    @(negedge clock);
    trig = 1'b0;
    vram.ra_vram_wait = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("first_write_latency", 32'(lat), 32'd7);
    chk($sformatf("c%0d_write_count", c), 32'(ncap), 32'((cfgs[c].ntiles + HEAD) * cfgs[c].nw));
    off = HEAD * cfgs[c].nw;
`ifdef RA_DUMMY_HEAD_EN
    chk("head_ctrl", cap_d[0], {1'b0, cfgs[c].zc, 1'b0, cfgs[c].fl, 28'd0});
    chk("head_addr", 32'(cap_a[0]), 32'({1'b0, cfgs[c].region[22:0]}));
    for (int i = 1; i < cfgs[c].nw; i++) chk($sformatf("head_ptr%0d", i), cap_d[i], 32'h8000_0000);
`endif
    foreach (exps[i]) begin
      if (exps[i].c == c) begin
        chk($sformatf("c%0d_w%0d_data", c, exps[i].idx), cap_d[exps[i].idx + off], exps[i].data);
        chk($sformatf("c%0d_w%0d_addr", c, exps[i].idx), 32'(cap_a[exps[i].idx + off]),
            32'(exps[i].addr + 24'(4 * off)));
      end
    end
  endtask
  initial begin
    cfgs[0] = '{32'h0000_0000, 32'h0000_0001, 32'h0020_0000, 24'h001000, 6'd1, 6'd0, 1'b0, 1'b0, 5, 2, 24'h001040};
    cfgs[1] = '{32'h0020_0000, 32'h0001_1111, 32'h0000_0100, 24'h000000, 6'd0, 6'd0, 1'b0, 1'b0, 6, 1, 24'h0000A0};
    cfgs[2] = '{32'hFFDF_FFFF, 32'hFFFF_FDCE, 32'hFF7F_FFF0, 24'h000400, 6'd3, 6'd2, 1'b1, 1'b1, 5, 12, 24'h000E80};
    cfgs[3] = '{32'h0020_0000, 32'h0001_0001, 32'h0000_1000, 24'h000010, 6'd1, 6'd1, 1'b0, 1'b0, 6, 4, 24'h000110};
    exps.push_back('{0, 0, 24'h200000, 32'h0000_0000});
    exps.push_back('{0, 1, 24'h200004, 32'h0000_1000});
    exps.push_back('{0, 2, 24'h200008, 32'h8000_0000});
    exps.push_back('{0, 4, 24'h200010, 32'h8000_0000});
    exps.push_back('{0, 5, 24'h200014, 32'h8000_0004});
    exps.push_back('{0, 6, 24'h200018, 32'h0000_1020});
    exps.push_back('{0, 9, 24'h200024, 32'h8000_0000});
    exps.push_back('{1, 0, 24'h000100, 32'h8000_0000});
    exps.push_back('{1, 1, 24'h000104, 32'h0000_0000});
    exps.push_back('{1, 2, 24'h000108, 32'h0000_0020});
    exps.push_back('{1, 3, 24'h00010C, 32'h0000_0040});
    exps.push_back('{1, 4, 24'h000110, 32'h0000_0060});
    exps.push_back('{1, 5, 24'h000114, 32'h0000_0080});
    exps.push_back('{2, 0, 24'h7FFFF0, 32'h5000_0000});
    exps.push_back('{2, 1, 24'h7FFFF4, 32'h0000_0400});
    exps.push_back('{2, 2, 24'h7FFFF8, 32'h8000_0000});
    exps.push_back('{2, 3, 24'h7FFFFC, 32'h0000_0700});
    exps.push_back('{2, 4, 24'h800000, 32'h0000_0880});
    exps.push_back('{2, 5, 24'h800004, 32'h5000_0004});
    exps.push_back('{2, 6, 24'h800008, 32'h0000_0440});
    exps.push_back('{2, 20, 24'h800040, 32'h5000_0100});
    exps.push_back('{2, 55, 24'h8000CC, 32'hD000_020C});
    exps.push_back('{2, 56, 24'h8000D0, 32'h0000_06C0});
    exps.push_back('{2, 57, 24'h8000D4, 32'h8000_0000});
    exps.push_back('{2, 58, 24'h8000D8, 32'h0000_0860});
    exps.push_back('{2, 59, 24'h8000DC, 32'h0000_0E00});
    exps.push_back('{3, 0, 24'h001000, 32'h0000_0000});
    exps.push_back('{3, 1, 24'h001004, 32'h0000_0010});
    exps.push_back('{3, 5, 24'h001014, 32'h0000_0090});
    exps.push_back('{3, 6, 24'h001018, 32'h0000_0004});
    exps.push_back('{3, 7, 24'h00101C, 32'h0000_0030});
    exps.push_back('{3, 11, 24'h00102C, 32'h0000_00B0});
    exps.push_back('{3, 12, 24'h001030, 32'h0000_0100});
    exps.push_back('{3, 18, 24'h001048, 32'h8000_0104});
    exps.push_back('{3, 19, 24'h00104C, 32'h0000_0070});
    exps.push_back('{3, 20, 24'h001050, 32'h8000_0000});
    exps.push_back('{3, 23, 24'h00105C, 32'h0000_00F0});
    vram.ra_vram_wait = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_wr", 32'(vram.ra_vram_wr), 32'd0);
    chk("rst_addr", 32'(vram.ra_vram_addr), 32'd0);
    chk("rst_dout", vram.ra_vram_dout, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ol_end", 32'(ol_end), 32'd0);
    reset = 1'b0;
    run(0, 1'b0, 0, 1'b0);
    run(1, 1'b0, 0, 1'b0);
    run(2, 1'b0, 0, 1'b1);
    run(3, 1'b0, 0, 1'b0);
    run(3, 1'b1, 0, 1'b0);
    run(0, 1'b0, 3, 1'b0);
    run(0, 1'b0, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
